// File: rtl/gate_pulse_decoder_pkg.sv
// Shared definitions for the gate pulse decoder: FSM state encoding and default timing.
// The state encoding is shared with the pulse stretcher users on the same ROC lines.
package gate_pulse_decoder_pkg;

   typedef enum logic [2:0] {
      ST_BLANK   = 3'd0,
      ST_ARM     = 3'd1,
      ST_IDLE    = 3'd2,
      ST_QUAL    = 3'd3,
      ST_ACTIVE  = 3'd4,
      ST_HOLDOFF = 3'd5
   } gate_state_e;

   localparam int unsigned BLANK_DEFAULT = 240;
   localparam int unsigned TMR_W         = 16;
   localparam int unsigned EVT_W         = 16;

   // Terminal value of a "count N clocks" timer that starts at 0; N=0 behaves like N=1.
   function automatic logic [TMR_W-1:0] last_tick(input int unsigned n);
      return (n > 0) ? TMR_W'(n - 1) : '0;
   endfunction

endpackage

// File: rtl/gate_pulse_decoder_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, cleared to 0 by reset.
module sync_2ff (
   input  logic clk_i,
   input  logic resetn_i,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/gate_pulse_decoder.sv
// Decodes a deglitched asynchronous gate of either polarity into a one-clock event pulse,
// measuring its width and flagging runt and over-long gates.
module gate_pulse_decoder
   import gate_pulse_decoder_pkg::*;
#(
   parameter int unsigned MIN_W = 2,
   parameter int unsigned MAX_W = 200,
   parameter int unsigned HOLD  = 4,
   parameter int unsigned BLANK = BLANK_DEFAULT,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             polarity_i,
   input  logic             gate_i,
   output logic             pulse_o,
   output logic [CNT_W-1:0] width_o,
   output logic             width_valid_o,
   output logic             glitch_o,
   output logic             overlong_o,
   output logic             busy_o,
   output logic [EVT_W-1:0] evt_cnt_o
);

   localparam logic [TMR_W-1:0] BLANK_LAST = last_tick(BLANK);
   localparam logic [TMR_W-1:0] HOLD_LAST  = last_tick(HOLD);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] MIN_W_C    = CNT_W'(MIN_W);
   localparam logic [CNT_W-1:0] MAX_W_C    = CNT_W'(MAX_W);

   logic w_gate_pol;
   logic w_s;
   logic [CNT_W-1:0] w_cnt_inc;

   gate_state_e      r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n;
   logic [TMR_W-1:0] r_tmr, w_tmr_n;
   logic [CNT_W-1:0] r_width, w_width_n;
   logic [EVT_W-1:0] r_evt_cnt, w_evt_n;
   logic             r_pulse, w_pulse_n;
   logic             r_width_valid, w_width_valid_n;
   logic             r_glitch, w_glitch_n;
   logic             r_overlong, w_overlong_n;
   logic             r_busy;

   // Polarity is folded in ahead of the synchroniser so everything downstream is active-high.
   assign w_gate_pol = polarity_i ? gate_i : ~gate_i;

   sync_2ff u_sync (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .d_i      (w_gate_pol),
      .q_o      (w_s)
   );

   assign w_cnt_inc = r_cnt + 1'b1;

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      w_state_n       = r_state;
      w_cnt_n         = r_cnt;
      w_tmr_n         = r_tmr;
      w_width_n       = r_width;
      w_evt_n         = r_evt_cnt;
      w_pulse_n       = 1'b0;
      w_width_valid_n = 1'b0;
      w_glitch_n      = 1'b0;
      w_overlong_n    = 1'b0;

      unique case (r_state)
         ST_BLANK: begin
            if (r_tmr == BLANK_LAST) begin
               w_tmr_n   = '0;
               w_state_n = ST_ARM;
            end else begin
               w_tmr_n = r_tmr + 1'b1;
            end
         end
         ST_ARM: begin
            // A gate already asserted here started unseen, so it is never decoded.
            if (!w_s) w_state_n = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_s) begin
               w_cnt_n = CNT_W'(1);
               if (MIN_W <= 1) begin
                  w_state_n = ST_ACTIVE;
                  w_pulse_n = 1'b1;
                  w_evt_n   = r_evt_cnt + 1'b1;
               end else begin
                  w_state_n = ST_QUAL;
               end
            end
         end
         ST_QUAL: begin
            if (w_s) begin
               w_cnt_n = w_cnt_inc;
               if (w_cnt_inc == MIN_W_C) begin
                  w_state_n = ST_ACTIVE;
                  w_pulse_n = 1'b1;
                  w_evt_n   = r_evt_cnt + 1'b1;
               end
            end else begin
               w_glitch_n = 1'b1;
               w_state_n  = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (w_s) begin
               if (r_cnt != CNT_MAX) begin
                  w_cnt_n      = w_cnt_inc;
                  w_overlong_n = (w_cnt_inc == MAX_W_C);
               end
            end else begin
               w_width_n       = r_cnt;
               w_width_valid_n = 1'b1;
               w_tmr_n         = '0;
               w_state_n       = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (r_tmr == HOLD_LAST) begin
               w_tmr_n   = '0;
               w_state_n = w_s ? ST_ARM : ST_IDLE;
            end else begin
               w_tmr_n = r_tmr + 1'b1;
            end
         end
         default: w_state_n = ST_BLANK;
      endcase
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state       <= ST_BLANK;
         r_cnt         <= '0;
         r_tmr         <= '0;
         r_width       <= '0;
         r_evt_cnt     <= '0;
         r_pulse       <= 1'b0;
         r_width_valid <= 1'b0;
         r_glitch      <= 1'b0;
         r_overlong    <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_cnt         <= w_cnt_n;
         r_tmr         <= w_tmr_n;
         r_width       <= w_width_n;
         r_evt_cnt     <= w_evt_n;
         r_pulse       <= w_pulse_n;
         r_width_valid <= w_width_valid_n;
         r_glitch      <= w_glitch_n;
         r_overlong    <= w_overlong_n;
         r_busy        <= (w_state_n != ST_IDLE);
      end
   end

   assign pulse_o       = r_pulse;
   assign width_o       = r_width;
   assign width_valid_o = r_width_valid;
   assign glitch_o      = r_glitch;
   assign overlong_o    = r_overlong;
   assign busy_o        = r_busy;
   assign evt_cnt_o     = r_evt_cnt;

endmodule
